player1_ctrl: RTL
=================

# player1_ctrl

Per-frame movement and animation sequencer for player 1. Once per video frame it samples the direction buttons and computes the candidate sprite position. It checks the two leading-edge tiles against the map through a 1-cycle-latency tile lookup port, then commits the position and animation frame. It drives `centerX1`, `centerY1` and `sprite_num` of the player-1 sprite renderer.

## Interface
Parameters:
- `START_X`, 32: reset value of `centerX1` (sprite top-left, pixels).
- `START_Y`, 32: reset value of `centerY1`.
- `SPEED`, 2: pixels moved per frame tick, 1..31.
- `X_MAX`, 768: largest legal `centerX1`, which is HACTIVE-32.
- `Y_MAX`, 544: largest legal `centerY1`, which is VACTIVE-32 rounded down to a multiple of 32.
- `ANIM_DIV`, 8: frame ticks per walk-phase toggle, 1..255.

Ports:
- `clk`, in, 1: pixel clock.
- `reset`, in, 1: asynchronous, active-high.
- `frame_tick`, in, 1: one-cycle pulse at end of active video.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, in, 1 each: level inputs, already debounced.
- `tile_req`, out, 1: tile lookup strobe.
- `tile_x`, out, 5: tile column, equal to pixel x >> 5.
- `tile_y`, out, 5: tile row, equal to pixel y >> 5.
- `tile_solid`, in, 1: valid exactly one cycle after `tile_req`. 1 means wall or block.
- `centerX1`, `centerY1`, out, signed 11: sprite top-left position.
- `sprite_num`, out, 3: sprite index, always 0..6.
- `busy`, out, 1: high when the state machine is not in IDLE.

## Operation
Sprite codes:
- 0..3: stand facing down, up, left, right.
- 4: step, vertical.
- 5: step, left.
- 6: step, right.

Direction priority: up > down > left > right. Only one axis moves per frame.

Candidate position:
- nx = clamp(centerX1 ± SPEED, 0, X_MAX). ny is computed the same way.
- Arithmetic is 12-bit signed, then truncated to 11 bits after the clamp.

Leading-edge corners, A then B:
- up: (nx, ny) then (nx+31, ny).
- down: (nx, ny+31) then (nx+31, ny+31).
- left: (nx, ny) then (nx, ny+31).
- right: (nx+31, ny) then (nx+31, ny+31).

State machine:
- IDLE, on tick with a direction pressed: latch direction and nx/ny, set facing. Go to REQ_A.
- IDLE, on tick with no button: set `sprite_num` = facing, clear the phase and anim counter. Stay in IDLE.
- REQ_A: drive `tile_req`=1 with corner A. Go to REQ_B.
- REQ_B: drive `tile_req`=1 with corner B. Latch `tile_solid` as solid_A. Go to EVAL.
- EVAL: if solid_A, `tile_solid`, and the clamp are all clear, and the position actually changes, then commit nx/ny and advance the animation. Otherwise leave the position unchanged and output the stand sprite. Go to IDLE.

Animation:
- An 8-bit counter increments on each committed move.
- When it reaches ANIM_DIV it wraps to 0 and the walk phase toggles.
- Phase 0 outputs the stand sprite for the facing direction.
- Phase 1 outputs the step sprite (4, 5 or 6) for the facing direction.

Boundary rules:
- A move fully absorbed by the clamp (already at the edge) counts as blocked.
- A `frame_tick` while `busy`=1 is ignored and not queued.
- Buttons are sampled only in the tick cycle. Later changes do not affect the move in progress.
- Opposite buttons pressed together resolve by priority, for example up+down gives up.

## Timing
- Tick in cycle 0:
  - `tile_req` is high in cycles 1 and 2.
  - Position and `sprite_num` are updated at the end of cycle 3, so they are visible in cycle 4.
  - `busy` is high in cycles 1–3.
- Tick with no direction: `sprite_num` updates in cycle 1. No `tile_req` is issued.
- `tile_req` is 0 outside REQ_A and REQ_B. `tile_x` and `tile_y` are don't-care when `tile_req`=0.
- Outputs are stable for the whole active frame because updates happen only after the tick.
- Reset values:
  - `centerX1`=START_X, `centerY1`=START_Y.
  - `sprite_num`=0, `tile_req`=0, `busy`=0.
  - facing=down, phase=0, counter=0, state IDLE.
- Reset asserted mid-sequence aborts the sequence. No partial commit occurs.

## Structure
- Shared package `bomberman_pkg` holds:
  - `dir_t` enum: DOWN, UP, LEFT, RIGHT.
  - Sprite code constants `SPR_STAND_*` and `SPR_STEP_*`.
  - `TILE_SIZE`=32, `TILE_SHIFT`=5.
  - HACTIVE/VACTIVE, so renderers and controllers share them.
- One sub-module, `player_anim`: the anim counter, phase toggle and sprite_num encode from (facing, moved, stand_req).

## Test plan
- Reset, then a tick with no button: position stays (32,32), `sprite_num`=0, no `tile_req`.
- Hold right with an open map, 3 ticks: `centerX1` goes 34, 36, 38. Each tick gives `tile_req` in cycles 1–2 with tile (2,1) then (2,1) (pixel y=63). Update lands in cycle 4.
- Hold right into a wall: tile_solid=1 on corner B only gives no position change, `sprite_num`=3.
- Hold left from x=1 with SPEED=2: the first tick gives x=0 and a step. The second tick is blocked by the clamp, giving stand sprite 2 and no position change.
- Hold down with ANIM_DIV=2, 4 ticks: `sprite_num` sequence 0, 4, 4, 0.
- Up+left pressed: moves up only. A tick during `busy` is ignored. Reset in cycle 2 gives outputs at their reset values immediately.

Source files
------------

// File: rtl/bomberman_pkg.sv
// Shared definitions for the bomberman video game: screen geometry,
// tile geometry, facing directions and player sprite codes.
package bomberman_pkg;

    typedef enum logic [1:0] {
        DOWN  = 2'd0,
        UP    = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    localparam logic [2:0] SPR_STAND_DOWN  = 3'd0;
    localparam logic [2:0] SPR_STAND_UP    = 3'd1;
    localparam logic [2:0] SPR_STAND_LEFT  = 3'd2;
    localparam logic [2:0] SPR_STAND_RIGHT = 3'd3;
    localparam logic [2:0] SPR_STEP_VERT   = 3'd4;
    localparam logic [2:0] SPR_STEP_LEFT   = 3'd5;
    localparam logic [2:0] SPR_STEP_RIGHT  = 3'd6;

    localparam int TILE_SIZE  = 32;
    localparam int TILE_SHIFT = 5;
    localparam int HACTIVE    = 800;
    localparam int VACTIVE    = 600;

    function automatic logic [2:0] stand_sprite(input dir_t d);
        unique case (d)
            UP:      return SPR_STAND_UP;
            LEFT:    return SPR_STAND_LEFT;
            RIGHT:   return SPR_STAND_RIGHT;
            default: return SPR_STAND_DOWN;
        endcase
    endfunction

    function automatic logic [2:0] step_sprite(input dir_t d);
        unique case (d)
            LEFT:    return SPR_STEP_LEFT;
            RIGHT:   return SPR_STEP_RIGHT;
            default: return SPR_STEP_VERT;
        endcase
    endfunction

endpackage

// File: rtl/player1_ctrl_anim.sv
// player_anim: walk animation counter, phase toggle and sprite encode.
// Ports: clk, reset, facing, moved/blocked/stand_req strobes -> sprite_num.
module player_anim
    import bomberman_pkg::*;
#(
    parameter int ANIM_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  dir_t       facing,
    input  logic       moved,
    input  logic       blocked,
    input  logic       stand_req,
    output logic [2:0] sprite_num
);

    localparam logic [7:0] DIV = 8'(ANIM_DIV);

    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic       phase;

    assign cnt_inc = cnt + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= 8'd0;
            phase      <= 1'b0;
            sprite_num <= SPR_STAND_DOWN;
        end else if (stand_req) begin
            cnt        <= 8'd0;
            phase      <= 1'b0;
            sprite_num <= stand_sprite(facing);
        end else if (moved) begin
            if (cnt_inc == DIV) begin
                // wrap: phase flips, sprite follows the new phase
                cnt        <= 8'd0;
                phase      <= ~phase;
                sprite_num <= phase ? stand_sprite(facing)
                                    : step_sprite(facing);
            end else begin
                cnt        <= cnt_inc;
                sprite_num <= phase ? step_sprite(facing)
                                    : stand_sprite(facing);
            end
        end else if (blocked) begin
            sprite_num <= stand_sprite(facing);
        end
    end

endmodule

// File: rtl/player1_ctrl.sv
// Player-1 per-frame movement sequencer: samples buttons on frame_tick,
// checks two leading-edge tiles (1-cycle lookup), then commits position.
// Ports: clk, reset, frame_tick, btn_*, tile_req/x/y, tile_solid,
//        centerX1, centerY1, sprite_num, busy.
module player1_ctrl
    import bomberman_pkg::*;
#(
    parameter int START_X  = 32,
    parameter int START_Y  = 32,
    parameter int SPEED    = 2,
    parameter int X_MAX    = 768,
    parameter int Y_MAX    = 544,
    parameter int ANIM_DIV = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    output logic               tile_req,
    output logic [4:0]         tile_x,
    output logic [4:0]         tile_y,
    input  logic               tile_solid,
    output logic signed [10:0] centerX1,
    output logic signed [10:0] centerY1,
    output logic [2:0]         sprite_num,
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_REQ_A, S_REQ_B, S_EVAL} state_t;

    localparam logic signed [11:0] SPD = 12'(SPEED);
    localparam logic signed [11:0] XM  = 12'(X_MAX);
    localparam logic signed [11:0] YM  = 12'(Y_MAX);

    state_t            state;
    dir_t              dir;
    dir_t              btn_dir;
    logic              any_btn;
    logic              solid_a;
    logic              commit;
    logic signed [10:0] nx_q, ny_q;
    logic signed [10:0] cand_x, cand_y;

    function automatic logic signed [10:0] step_clamp(
        input logic signed [10:0] p,
        input logic               neg,
        input logic signed [11:0] lim
    );
        logic signed [11:0] pe;
        logic signed [11:0] s;
        pe = {p[10], p};
        s  = neg ? (pe - SPD) : (pe + SPD);
        if (s < 0)
            s = 12'sd0;
        else if (s > lim)
            s = lim;
        return 11'(s);
    endfunction

    // tile index of a pixel, optionally at the far (+31) sprite edge
    function automatic logic [4:0] tile_of(
        input logic signed [10:0] p,
        input logic               far
    );
        logic [11:0] s;
        s = {p[10], p} + (far ? 12'd31 : 12'd0);
        return 5'(s >> TILE_SHIFT);
    endfunction

    always_comb begin
        any_btn = btn_up | btn_down | btn_left | btn_right;
        btn_dir = RIGHT;
        if (btn_up)
            btn_dir = UP;
        else if (btn_down)
            btn_dir = DOWN;
        else if (btn_left)
            btn_dir = LEFT;
        cand_x = centerX1;
        cand_y = centerY1;
        unique case (btn_dir)
            UP:    cand_y = step_clamp(centerY1, 1'b1, YM);
            DOWN:  cand_y = step_clamp(centerY1, 1'b0, YM);
            LEFT:  cand_x = step_clamp(centerX1, 1'b1, XM);
            RIGHT: cand_x = step_clamp(centerX1, 1'b0, XM);
        endcase
    end

    // a move fully absorbed by the clamp leaves nx/ny equal: blocked
    assign commit = !solid_a && !tile_solid &&
                    ((nx_q != centerX1) || (ny_q != centerY1));
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            dir      <= DOWN;
            nx_q     <= 11'(START_X);
            ny_q     <= 11'(START_Y);
            solid_a  <= 1'b0;
            tile_req <= 1'b0;
            tile_x   <= 5'd0;
            tile_y   <= 5'd0;
            centerX1 <= 11'(START_X);
            centerY1 <= 11'(START_Y);
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (frame_tick && any_btn) begin
                        dir      <= btn_dir;
                        nx_q     <= cand_x;
                        ny_q     <= cand_y;
                        tile_req <= 1'b1;
                        tile_x   <= tile_of(cand_x, btn_dir == RIGHT);
                        tile_y   <= tile_of(cand_y, btn_dir == DOWN);
                        state    <= S_REQ_A;
                    end
                end
                S_REQ_A: begin
                    tile_req <= 1'b1;
                    tile_x   <= tile_of(nx_q, dir != LEFT);
                    tile_y   <= tile_of(ny_q, dir != UP);
                    state    <= S_REQ_B;
                end
                S_REQ_B: begin
                    solid_a  <= tile_solid;
                    tile_req <= 1'b0;
                    state    <= S_EVAL;
                end
                S_EVAL: begin
                    if (commit) begin
                        centerX1 <= nx_q;
                        centerY1 <= ny_q;
                    end
                    state <= S_IDLE;
                end
            endcase
        end
    end

    player_anim #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .clk        (clk),
        .reset      (reset),
        .facing     (dir),
        .moved      (state == S_EVAL && commit),
        .blocked    (state == S_EVAL && !commit),
        .stand_req  (state == S_IDLE && frame_tick && !any_btn),
        .sprite_num (sprite_num)
    );

endmodule
